alu_exec_unit: RTL and testbench

//  Sequential responder for ALU requests from the decode/control stage: accepts one op per valid/ready handshake and

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_core.sv | 27 ++
 rtl/alu_exec_unit.sv | 127 ++++++++++++
 tb/tb_alu_exec_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU execute unit.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_MOV   = 3'b000,
        OP_CMP   = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_NEG   = 3'b100,
        OP_SHIFT = 3'b101,
        OP_LOGIC = 3'b110,
        OP_RSVD  = 3'b111
    } aluop_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // CMP only sets flags; the reserved opcode neither writes nor touches flags.
    function automatic logic op_writes(aluop_t op);
        return !(op == OP_CMP || op == OP_RSVD);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the decode/control stage and the ALU execute unit.
interface alu_exec_unit_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic             InValid;
    logic             InReady;
    logic [2:0]       Aluop;
    logic [WIDTH-1:0] DatA;
    logic [WIDTH-1:0] DatB;
    logic             LSL_sel;
    logic             ORR_sel;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Rslt;
    logic             WrEn;
    logic             Zero;
    logic             Neg;
    logic             Busy;

    modport master (
        output InValid, Aluop, DatA, DatB, LSL_sel, ORR_sel, OutReady,
        input  InReady, OutValid, Rslt, WrEn, Zero, Neg, Busy
    );

    modport slave (
        input  InValid, Aluop, DatA, DatB, LSL_sel, ORR_sel, OutReady,
        output InReady, OutValid, Rslt, WrEn, Zero, Neg, Busy
    );

endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops; shifts and the reserved op yield zero here.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  aluop_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             orr_sel,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_MOV:   result = b;
            OP_CMP:   result = a - b;
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_NEG:   result = '0 - a;
            OP_LOGIC: result = orr_sel ? (a | b) : (a & b);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute unit: single-cycle ops via alu_core, iterative 1-bit/cycle shifts,
// held result with write-enable, and the Zero/Neg flag register.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input logic            Clk,
    input logic            Reset_n,
    alu_exec_unit_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [CntW-1:0]  cnt_q;
    logic             shr_q;
    logic [WIDTH-1:0] rslt_q;
    logic             wr_en_q;
    logic             out_valid_q;
    logic             zero_q;
    logic             neg_q;

    aluop_t           op;
    logic             accept;
    logic             shift_start;
    logic             take_only;
    logic             finish;
    logic [CntW-1:0]  amt;
    logic [WIDTH-1:0] core_rslt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fin_rslt;
    logic             fin_wr;
    logic             fin_upd;

    assign op          = aluop_t'(bus.Aluop);
    assign bus.InReady = (state_q == S_IDLE) || (state_q == S_DONE && bus.OutReady);
    assign accept      = bus.InValid && bus.InReady;
    assign shift_start = accept && (op == OP_SHIFT) && (amt != '0);
    assign take_only   = (state_q == S_DONE) && bus.OutReady && !bus.InValid;
    assign shifted     = shr_q ? (work_q >> 1) : (work_q << 1);

    assign bus.Rslt     = rslt_q;
    assign bus.WrEn     = wr_en_q;
    assign bus.OutValid = out_valid_q;
    assign bus.Zero     = zero_q;
    assign bus.Neg      = neg_q;
    assign bus.Busy     = (state_q != S_IDLE);

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op      (op),
        .a       (bus.DatA),
        .b       (bus.DatB),
        .orr_sel (bus.ORR_sel),
        .result  (core_rslt)
    );

    // Shift amounts of WIDTH or more saturate: WIDTH iterations always clear the word.
    always_comb begin
        amt = CntW'(WIDTH);
        if (bus.DatB < WIDTH'(WIDTH)) begin
            amt = CntW'(bus.DatB);
        end
    end

    // Value, write-enable and flag update for whichever result lands in DONE this edge.
    always_comb begin
        finish   = 1'b0;
        fin_rslt = core_rslt;
        fin_wr   = op_writes(op);
        fin_upd  = (op != OP_RSVD);
        if (state_q == S_SHIFT) begin
            finish   = (cnt_q == CntW'(1));
            fin_rslt = shifted;
            fin_wr   = 1'b1;
            fin_upd  = 1'b1;
        end else if (accept && !shift_start) begin
            finish = 1'b1;
            if (op == OP_SHIFT) begin
                fin_rslt = bus.DatA;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            shr_q       <= 1'b0;
            rslt_q      <= '0;
            wr_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            if (state_q == S_SHIFT) begin
                work_q <= shifted;
                cnt_q  <= cnt_q - CntW'(1);
            end else if (shift_start) begin
                state_q     <= S_SHIFT;
                work_q      <= bus.DatA;
                cnt_q       <= amt;
                shr_q       <= bus.LSL_sel;
                out_valid_q <= 1'b0;
            end else if (take_only) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
            end

            if (finish) begin
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
                rslt_q      <= fin_rslt;
                wr_en_q     <= fin_wr;
                if (fin_upd) begin
                    zero_q <= (fin_rslt == '0);
                    neg_q  <= fin_rslt[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

    logic Clk;
    logic Reset_n;
    int   n_total;
    int   n_bad;

    alu_exec_unit_if #(.WIDTH(8)) bus ();

    alu_exec_unit #(
        .WIDTH (8)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic lsl, input logic orr);
        bus.InValid = 1'b1;
        bus.Aluop   = op;
        bus.DatA    = a;
        bus.DatB    = b;
        bus.LSL_sel = lsl;
        bus.ORR_sel = orr;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic lsl, input logic orr,
                          input int exp_lat, input logic [7:0] exp_r, input logic exp_we,
                          input logic exp_z, input logic exp_n);
        int lat;
        @(negedge Clk);
        drive(op, a, b, lsl, orr);
        check({tag, "_inready"}, 32'(bus.InReady), 32'd1);
        @(posedge Clk);
        #1 bus.InValid = 1'b0;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!bus.OutValid && lat < 20);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rslt"}, 32'(bus.Rslt), 32'(exp_r));
        check({tag, "_wren"}, 32'(bus.WrEn), 32'(exp_we));
        check({tag, "_zero"}, 32'(bus.Zero), 32'(exp_z));
        check({tag, "_neg"}, 32'(bus.Neg), 32'(exp_n));
    endtask

    initial begin
        int seen;
        n_total  = 0;
        n_bad    = 0;
        Reset_n  = 1'b0;
        bus.InValid  = 1'b0;
        bus.Aluop    = 3'd0;
        bus.DatA     = 8'd0;
        bus.DatB     = 8'd0;
        bus.LSL_sel  = 1'b0;
        bus.ORR_sel  = 1'b0;
        bus.OutReady = 1'b1;

        // Reset values
        #12;
        check("rst_rslt", 32'(bus.Rslt), 32'd0);
        check("rst_wren", 32'(bus.WrEn), 32'd0);
        check("rst_ovalid", 32'(bus.OutValid), 32'd0);
        check("rst_flags", 32'({bus.Zero, bus.Neg}), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Reset mid-shift: LSL 1 by 5, reset after 2 shift cycles
        @(negedge Clk);
        drive(3'b101, 8'd1, 8'd5, 1'b0, 1'b0);
        @(posedge Clk);
        #1 bus.InValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("midshift_busy", 32'(bus.Busy), 32'd1);
        check("midshift_inready", 32'(bus.InReady), 32'd0);
        Reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.Busy), 32'd0);
        check("arst_outs", 32'({bus.Rslt, bus.WrEn, bus.OutValid, bus.Zero, bus.Neg}), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (bus.OutValid) seen++;
        end
        check("arst_no_ovalid", 32'(seen), 32'd0);

        // Arithmetic
        run_op("add", 3'b010, 8'd10, 8'd5, 1'b0, 1'b0, 1, 8'd15, 1'b1, 1'b0, 1'b0);
        run_op("sub", 3'b011, 8'd5, 8'd15, 1'b0, 1'b0, 1, 8'd246, 1'b1, 1'b0, 1'b1);
        run_op("neg", 3'b100, 8'd1, 8'd0, 1'b0, 1'b0, 1, 8'd255, 1'b1, 1'b0, 1'b1);

        // Compare, move, reserved
        run_op("cmp", 3'b001, 8'd20, 8'd20, 1'b0, 1'b0, 1, 8'd0, 1'b0, 1'b1, 1'b0);
        run_op("mov", 3'b000, 8'd3, 8'h80, 1'b0, 1'b0, 1, 8'd128, 1'b1, 1'b0, 1'b1);
        run_op("rsvd", 3'b111, 8'd7, 8'd9, 1'b0, 1'b0, 1, 8'd0, 1'b0, 1'b0, 1'b1);

        // Shifts
        run_op("lsl2", 3'b101, 8'd4, 8'd2, 1'b0, 1'b0, 3, 8'd16, 1'b1, 1'b0, 1'b0);
        run_op("lsr1", 3'b101, 8'd16, 8'd1, 1'b1, 1'b0, 2, 8'd8, 1'b1, 1'b0, 1'b0);
        run_op("lsl0", 3'b101, 8'h5A, 8'd0, 1'b0, 1'b0, 1, 8'h5A, 1'b1, 1'b0, 1'b0);
        run_op("lsl200", 3'b101, 8'hFF, 8'd200, 1'b0, 1'b0, 9, 8'd0, 1'b1, 1'b1, 1'b0);
        run_op("lsr7", 3'b101, 8'h80, 8'd7, 1'b1, 1'b0, 8, 8'd1, 1'b1, 1'b0, 1'b0);

        // Back-to-back LOGIC, one result per cycle
        @(negedge Clk);
        drive(3'b110, 8'hAA, 8'hCC, 1'b0, 1'b0);
        @(posedge Clk);
        #1 drive(3'b110, 8'hAA, 8'hCC, 1'b0, 1'b1);
        @(negedge Clk);
        check("and_ovalid", 32'(bus.OutValid), 32'd1);
        check("and_rslt", 32'(bus.Rslt), 32'h88);
        check("and_neg", 32'(bus.Neg), 32'd1);
        check("b2b_inready", 32'(bus.InReady), 32'd1);
        @(posedge Clk);
        #1 bus.InValid = 1'b0;
        @(negedge Clk);
        check("orr_ovalid", 32'(bus.OutValid), 32'd1);
        check("orr_rslt", 32'(bus.Rslt), 32'hEE);
        @(negedge Clk);
        check("b2b_drain", 32'(bus.OutValid), 32'd0);

        // Backpressure: ADD 1+1 held while a second request waits
        bus.OutReady = 1'b0;
        run_op("bp_add", 3'b010, 8'd1, 8'd1, 1'b0, 1'b0, 1, 8'd2, 1'b1, 1'b0, 1'b0);
        drive(3'b011, 8'd9, 8'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("bp_ovalid", 32'(bus.OutValid), 32'd1);
            check("bp_rslt", 32'(bus.Rslt), 32'd2);
            check("bp_inready", 32'(bus.InReady), 32'd0);
            @(negedge Clk);
        end
        bus.OutReady = 1'b1;
        #1;
        check("bp_release_inready", 32'(bus.InReady), 32'd1);
        @(posedge Clk);
        #1 bus.InValid = 1'b0;
        @(negedge Clk);
        check("bp_next_ovalid", 32'(bus.OutValid), 32'd1);
        check("bp_next_rslt", 32'(bus.Rslt), 32'd5);
        check("bp_next_flags", 32'({bus.Zero, bus.Neg}), 32'd0);
        @(negedge Clk);
        check("bp_idle", 32'(bus.Busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
